// File: rtl/register_file_scoreboard.sv
// 31-entry integer register file with write-through bypass and a one-bit-per-register
// pending scoreboard that raises stall when a consumer reads an outstanding destination.
module register_file_scoreboard #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall
);

  logic [XLEN-1:0] regs_q [1:31];
  logic [31:1]     pend_q;
  logic [31:1]     pend_d;
  logic            wr_act;
  logic            issue_act;

  assign wr_act    = wr_en && (wr_addr != 5'd0);
  assign issue_act = issue_en && !stall && (issue_rd != 5'd0);

  // x0 has no storage; a same-cycle writeback to the read index is forwarded.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (wr_act && (wr_addr == rs1_addr)) rs1_data = wr_data;
      else                                 rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (wr_act && (wr_addr == rs2_addr)) rs2_data = wr_data;
      else                                 rs2_data = regs_q[rs2_addr];
    end
  end

  // A register being written back this cycle is no longer busy for its reader.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != 5'd0)
      rs1_busy = pend_q[rs1_addr] && !(wr_act && (wr_addr == rs1_addr));
    if (rs2_addr != 5'd0)
      rs2_busy = pend_q[rs2_addr] && !(wr_act && (wr_addr == rs2_addr));
  end

  assign stall = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);

  // Clear is applied before set so a same-edge issue to the written index stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_act)    pend_d[wr_addr]  = 1'b0;
    if (issue_act) pend_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_act) regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: reads, writes, bypass, scoreboard and reset.
module tb_register_file_scoreboard;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            rs1_used, rs2_used;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            issue_en;
  logic [4:0]      issue_rd;
  logic            rs1_busy, rs2_busy, stall;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_scoreboard #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_rd = 0;
    rs1_used = 0; rs2_used = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
    tick(); tick();
    rst = 0; rs1_addr = 5; rs2_addr = 0; rs1_used = 1; rs2_used = 1;
    #1;
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs1_data got %h exp %h", rs1_data, 32'h0); end
    n_checks++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs2_data got %h exp %h", rs2_data, 32'h0); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b%b exp 00", rs1_busy, rs2_busy); end
    idle();
  endtask

  task automatic test_write_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 0; rs1_addr = 5;
    #1;
    n_checks++; if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_x5 got %h exp %h", rs1_data, 32'hDEADBEEF); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL write_nonpending_busy got %b exp 0", rs1_busy); end
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs2_addr = 0;
    #1;
    n_checks++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL x0_no_bypass got %h exp 0", rs2_data); end
    tick();
    wr_en = 0;
    #1;
    n_checks++; if (rs2_data !== 32'h0) begin n_fail++; $display("FAIL x0_read got %h exp 0", rs2_data); end
    n_checks++; if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x5_kept got %h exp %h", rs1_data, 32'hDEADBEEF); end
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rs1_addr = 7; rs2_addr = 7;
    #1;
    n_checks++; if (rs1_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_rs1 got %h exp %h", rs1_data, 32'hA5A5A5A5); end
    n_checks++; if (rs2_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_rs2 got %h exp %h", rs2_data, 32'hA5A5A5A5); end
    n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got %b%b exp 00", rs1_busy, rs2_busy); end
    tick();
    wr_en = 0; rs2_addr = 5;
    #1;
    n_checks++; if (rs1_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL x7_stored got %h exp %h", rs1_data, 32'hA5A5A5A5); end
    n_checks++; if (rs2_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rs2_x5 got %h exp %h", rs2_data, 32'hDEADBEEF); end
  endtask

  task automatic test_scoreboard();
    idle(); rs1_addr = 0; rs2_addr = 0;
    issue_en = 1; issue_rd = 3;
    tick();
    issue_en = 0; rs2_addr = 3; rs2_used = 1;
    #1;
    n_checks++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL pend_x3_busy got %b exp 1", rs2_busy); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pend_x3_stall got %b exp 1", stall); end
    rs2_used = 0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_no_stall got %b exp 0", stall); end
    rs2_used = 1; wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wb_clears_stall got %b exp 0", stall); end
    n_checks++; if (rs2_data !== 32'h55) begin n_fail++; $display("FAIL wb_bypass_x3 got %h exp %h", rs2_data, 32'h55); end
    tick();
    wr_en = 0;
    #1;
    n_checks++; if (rs2_busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL x3_cleared got busy %b stall %b exp 0 0", rs2_busy, stall); end
    n_checks++; if (rs2_data !== 32'h55) begin n_fail++; $display("FAIL x3_stored got %h exp %h", rs2_data, 32'h55); end
    // Double issue then one write: no counting.
    rs2_used = 0; issue_en = 1; issue_rd = 3;
    tick(); tick();
    issue_en = 0; wr_en = 1; wr_addr = 3; wr_data = 32'h66;
    tick();
    wr_en = 0;
    #1;
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reissue_single_bit got %b exp 0", rs2_busy); end
    // Issue and write to different indices on the same edge.
    issue_en = 1; issue_rd = 12; wr_en = 1; wr_addr = 3; wr_data = 32'h77;
    tick();
    issue_en = 0; wr_en = 0; rs1_addr = 12; rs2_addr = 3;
    #1;
    n_checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL diff_idx_busy got %b%b exp 10", rs1_busy, rs2_busy); end
    n_checks++; if (rs2_data !== 32'h77) begin n_fail++; $display("FAIL diff_idx_data got %h exp %h", rs2_data, 32'h77); end
    wr_en = 1; wr_addr = 12; wr_data = 32'hC;
    tick();
    wr_en = 0;
    #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL x12_cleared got %b exp 0", rs1_busy); end
  endtask

  task automatic test_same_edge();
    idle(); rs1_addr = 0; rs2_addr = 0;
    issue_en = 1; issue_rd = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    tick();
    idle(); rs1_addr = 9; rs1_used = 1;
    #1;
    n_checks++; if (stall !== 1'b1 || rs1_busy !== 1'b1) begin n_fail++; $display("FAIL same_edge_set_wins got busy %b stall %b exp 1 1", rs1_busy, stall); end
    n_checks++; if (rs1_data !== 32'h99) begin n_fail++; $display("FAIL same_edge_data got %h exp %h", rs1_data, 32'h99); end
    issue_en = 1; issue_rd = 4;
    tick();
    issue_en = 0; rs2_addr = 4;
    #1;
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL stalled_issue_ignored got %b exp 0", rs2_busy); end
    rs1_used = 0;
    issue_en = 1; issue_rd = 0;
    tick();
    issue_en = 0; rs2_addr = 0;
    #1;
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL x0_never_busy got %b exp 0", rs2_busy); end
  endtask

  task automatic test_mid_reset();
    idle();
    issue_en = 1; issue_rd = 3;
    tick();
    issue_en = 0; wr_en = 1; wr_addr = 10; wr_data = 32'h77;
    tick();
    wr_en = 0; rs1_addr = 3; rs2_addr = 9; rs1_used = 1; rs2_used = 1;
    #1;
    n_checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got %b%b exp 11", rs1_busy, rs2_busy); end
    rst = 1; rs1_used = 0; rs2_used = 0;
    issue_en = 1; issue_rd = 5; wr_en = 1; wr_addr = 11; wr_data = 32'hBAD;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL busy_during_rst got %b exp 1", rs1_busy); end
    tick();
    rst = 0; idle(); rs1_addr = 3; rs2_addr = 9; rs1_used = 1; rs2_used = 1;
    #1;
    n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_scoreboard got busy %b%b stall %b exp 00 0", rs1_busy, rs2_busy, stall); end
    rs1_addr = 10; rs2_addr = 5;
    #1;
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL post_reset_x10 got %h exp 0", rs1_data); end
    n_checks++; if (rs2_data !== 32'h0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_x5 got %h busy %b exp 0 0", rs2_data, rs2_busy); end
    rs1_addr = 11;
    #1;
    n_checks++; if (rs1_data !== 32'h0) begin n_fail++; $display("FAIL write_during_rst_ignored got %h exp 0", rs1_data); end
    wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    tick();
    wr_en = 0; rs1_addr = 3;
    #1;
    n_checks++; if (rs1_data !== 32'h33 || rs1_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_wb got %h busy %b exp %h 0", rs1_data, rs1_busy, 32'h33); end
  endtask

  initial begin
    rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_same_edge();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width of every register.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rs1_addr  in  5  read port 1 register index.
REQ-005 rs2_addr  in  5  read port 2 register index.
REQ-006 rs1_used  in  1  consumer reads rs1 this cycle.
REQ-007 rs2_used  in  1  consumer reads rs2 this cycle.
REQ-008 rs1_data  out  XLEN  read port 1 data.
REQ-009 rs2_data  out  XLEN  read port 2 data.
REQ-010 wr_en  in  1  writeback strobe.
REQ-011 wr_addr  in  5  writeback register index.
REQ-012 wr_data  in  XLEN  writeback data.
REQ-013 issue_en  in  1  instruction with destination issues this cycle.
REQ-014 issue_rd  in  5  destination of issuing instruction (marked pending).
REQ-015 rs1_busy  out  1  rs1 has an outstanding write not yet available.
REQ-016 rs2_busy  out  1  rs2 has an outstanding write not yet available.
REQ-017 stall  out  1  consumer must hold; operand not ready.

Function
REQ-018 Storage: 31 registers x1..x31 of XLEN bits plus 31-bit pending vector; x0 has no storage.
REQ-019 Reads combinational, zero latency; index 0 returns all-zero regardless of writes.
REQ-020 Write: on clk edge with wr_en=1, wr_addr!=0, !rst -> reg[wr_addr] <= wr_data; wr_addr=0 ignored.
REQ-021 Bypass: wr_en=1, wr_addr==rsN_addr, rsN_addr!=0 -> rsN_data = wr_data in the same cycle.
REQ-022 Both ports SHALL bypass independently; rs1_addr==rs2_addr returns identical data.
REQ-023 Pending set: clk edge with issue_en=1, stall=0, issue_rd!=0, !rst -> pending[issue_rd] <= 1.
REQ-024 issue_en while stall=1 SHALL be ignored; issue_rd=0 never sets pending.
REQ-025 Pending clear: clk edge with wr_en=1, wr_addr!=0 -> pending[wr_addr] <= 0.
REQ-026 Same-edge issue and write to same index: set wins (pending=1), register still takes wr_data.
REQ-027 Same-edge issue and write to different indices: both take effect.
REQ-028 rsN_busy = pending[rsN_addr] & ~(wr_en & wr_addr==rsN_addr); always 0 for index 0.
REQ-029 stall = (rs1_used & rs1_busy) | (rs2_used & rs2_busy); purely combinational.
REQ-030 Write to non-pending register is legal: updates data, pending unchanged (stays 0).
REQ-031 Single pending bit per register; re-issue to an already-pending index leaves it pending, no counting.

Reset
REQ-032 On clk edge with rst=1: all registers <= 0, pending vector <= 0; wr_en and issue_en ignored that edge.
REQ-033 After reset edge: rs1_data=rs2_data=0 (absent bypass), rs1_busy=rs2_busy=0, stall=0.
REQ-034 rst asserted mid-operation discards all outstanding pending marks; later writeback to those indices is a normal write.
REQ-035 Bypass and busy logic stay combinational during rst; outputs reflect pre-reset state until the reset edge.

Verification
REQ-036 Reset, then rs1_addr=5, rs2_addr=0 -> rs1_data=0, rs2_data=0, stall=0.
REQ-037 Write x5=0xDEADBEEF; next cycle rs1_addr=5 -> 0xDEADBEEF; write x0=0x1234 -> rs2_addr=0 reads 0.
REQ-038 Same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rs1_addr=rs2_addr=7 -> both ports 0xA5A5A5A5 combinationally, busy=0.
REQ-039 issue_en, issue_rd=3; next cycle rs2_addr=3, rs2_used=1 -> rs2_busy=1, stall=1; then wr_en addr 3 data 0x55 -> stall=0 that cycle, rs2_data=0x55; next cycle pending clear.
REQ-040 Same edge issue_rd=9 and wr_addr=9 -> pending[9]=1 after edge (rs1_addr=9, rs1_used=1 gives stall=1); issue_en with stall=1 to x4 -> x4 not pending.
REQ-041 Set pending x3, x9, write x10=0x77, assert rst one cycle -> all busy=0, x10 reads 0, stall=0.
